// File: rtl/fp_sub_norm.sv
// Post-subtraction normaliser: left-justifies a 24-bit mantissa difference, adjusting the exponent.
// Latency: 1 cycle to out_valid when no shift is needed, plus 1 cycle per shift step (at most 23).
// Backpressure: accepts only in IDLE; the result is held in DONE until out_ready, with no overlap.
//
// Ports:
//   clk, rst                                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, in_mant/exp/sign      upstream handshake and raw difference
//   out_valid/out_ready, out_mant/exp/sign   downstream handshake and normalised result
//   out_zero, out_denorm, shift_cnt          status flags and total left-shift count
// Optional feature macro: NORM_BYTE_SKIP_EN (shift 8 at a time while the top byte is zero).
module fp_sub_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_mant,
  input  logic [7:0]  in_exp,
  input  logic        in_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_mant,
  output logic [7:0]  out_exp,
  output logic        out_sign,
  output logic        out_zero,
  output logic        out_denorm,
  output logic [4:0]  shift_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [23:0] mant_q, mant_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic        denorm_q, denorm_d;
  logic [4:0]  cnt_q, cnt_d;

  // One shift step. SHIFT is only entered with exp >= 2 and every step stops
  // at exp == 1, so the subtraction can never go below 1.
  logic [23:0] step_mant;
  logic [7:0]  step_exp;
  logic [4:0]  step_cnt;

  always_comb begin
    step_mant = {mant_q[22:0], 1'b0};
    step_exp  = exp_q - 8'd1;
    step_cnt  = cnt_q + 5'd1;
`ifdef NORM_BYTE_SKIP_EN
    // With the top byte clear and exp >= 9, none of the seven skipped single
    // steps could have terminated, so a byte jump gives the identical result.
    if ((mant_q[23:16] == 8'h00) && (exp_q >= 8'd9)) begin
      step_mant = {mant_q[15:0], 8'h00};
      step_exp  = exp_q - 8'd8;
      step_cnt  = cnt_q + 5'd8;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d   = in_mant;
          exp_d    = in_exp;
          sign_d   = in_sign;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          cnt_d    = 5'd0;
          if (in_mant == 24'h000000) begin
            state_d = DONE;
            exp_d   = 8'h00;
            zero_d  = 1'b1;
          end else if (in_mant[23]) begin
            state_d = DONE;
          end else if (in_exp <= 8'd1) begin
            state_d  = DONE;
            exp_d    = 8'h00;
            denorm_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_d = step_mant;
        exp_d  = step_exp;
        cnt_d  = step_cnt;
        if (step_mant[23]) begin
          state_d = DONE;
        end else if (step_exp == 8'd1) begin
          // Ran out of exponent before the hidden bit arrived: denormal.
          state_d  = DONE;
          exp_d    = 8'h00;
          denorm_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mant_q   <= 24'h000000;
      exp_q    <= 8'h00;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      cnt_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign out_mant   = mant_q;
  assign out_exp    = exp_q;
  assign out_sign   = sign_q;
  assign out_zero   = zero_q;
  assign out_denorm = denorm_q;
  assign shift_cnt  = cnt_q;

endmodule

// File: doc/fp_sub_norm.md
FP_SUB_NORM -- requirements
Module: fp_sub_norm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 in_valid  input  1  upstream mantissa-difference result valid.
REQ-003 in_ready  output  1  block can accept; high only in IDLE.
REQ-004 in_mant  input  24  raw mantissa difference from the 24-bit subtractor (hidden bit at [23]).
REQ-005 in_exp  input  8  biased exponent of the larger operand.
REQ-006 in_sign  input  1  result sign, passed through.
REQ-007 out_valid  output  1  normalized result valid.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 out_mant  output  24, out_exp  output  8, out_sign  output  1  normalized result.
REQ-010 out_zero  output  1, out_denorm  output  1, shift_cnt  output  5  status flags and total left-shift count.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 Accept SHALL occur on a rising edge with in_valid=1 in IDLE; inputs latched, shift_cnt cleared, out_sign=in_sign.
REQ-013 At accept, classification SHALL be in this priority order:
- in_mant==0 -> DONE; mant=0, exp=0, out_zero=1.
- in_mant[23]==1 -> DONE, unchanged.
- in_exp<=1 -> DONE; exp=0, out_denorm=1, mant unchanged.
- otherwise -> SHIFT.
REQ-014 Each SHIFT edge SHALL shift mant left 1 (zero fill), decrement exp by 1, and increment shift_cnt.
REQ-015 SHIFT SHALL go to DONE on the same edge when the new mant[23]==1 or the new exp==1; if new exp==1 with new mant[23]==0, exp SHALL be written 0 and out_denorm set.
REQ-016 Latency: k leading zeros with no denormal stop SHALL give out_valid=1 in the cycle after the k-th edge following accept (k=0 -> cycle after the accept edge); the maximum is 23 shift edges.
REQ-017 In DONE, out_valid=1 and all out_* SHALL be held stable until an edge with out_ready=1, then IDLE.
REQ-018 in_valid outside IDLE SHALL be ignored; there is no back-to-back accept in the DONE->IDLE cycle.
REQ-019 out_exp SHALL never underflow below 0 or wrap.

Reset
REQ-020 rst=1 at an edge SHALL force IDLE from any state, including mid-SHIFT; the in-flight operation is discarded.
REQ-021 Reset values SHALL be: out_valid=0, out_mant=0, out_exp=0, out_sign=0, out_zero=0, out_denorm=0, shift_cnt=0; in_ready=0 while rst=1, and 1 in the first IDLE cycle after.

Configuration
REQ-022 Macro NORM_BYTE_SKIP_EN: when defined, a SHIFT edge with mant[23:16]==0 and exp>=9 SHALL shift by 8, subtract 8 from exp, and add 8 to shift_cnt, applying the same termination test as REQ-015; otherwise it shifts by 1.
REQ-023 Without NORM_BYTE_SKIP_EN, only 1-bit shifts SHALL exist. Final out_* values SHALL be identical in both builds; only latency differs.

Verification
REQ-024 in_mant=0x800000, in_exp=0x80 -> out_valid in the cycle after accept; out_mant=0x800000, out_exp=0x80, shift_cnt=0.
REQ-025 in_mant=0x000001, in_exp=0x80 -> out_mant=0x800000, out_exp=0x69, shift_cnt=23; 23 SHIFT edges, or 9 with NORM_BYTE_SKIP_EN.
REQ-026 in_mant=0x000000, in_exp=0x55, in_sign=1 -> out_zero=1, out_mant=0, out_exp=0, out_sign=1, out_valid in the cycle after accept.
REQ-027 in_mant=0x000F00, in_exp=0x05 -> out_mant=0x00F000, out_exp=0, out_denorm=1, shift_cnt=4, identical in both builds.
REQ-028 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> outputs stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-029 Assert rst on the 3rd SHIFT edge of case REQ-025 -> next cycle IDLE, out_valid=0, shift_cnt=0; a new input is then processed correctly.
